// File: rtl/seven_segment_reader.sv
// Scanned seven-segment panel reader: samples a multiplexed active-low GFEDCBA bus,
// debounces each digit, decodes glyphs back to BCD and hands out one frame per scan.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              hex,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic                    sync_err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        SYNC,
        SETTLE,
        GAP,
        HOLD
    } state_t;

    state_t                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [6:0]              hex_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [CNT_W-1:0]        cnt;
    logic [4*NUM_DIGITS-1:0] shadow_bcd;
    logic [NUM_DIGITS-1:0]   shadow_err;
    logic [NUM_DIGITS-1:0]   cur_mask;
    logic [NUM_DIGITS-1:0]   prev_mask;
    logic                    legal;
    logic                    stable;
    logic [4:0]              dec;
    logic                    capture;
    logic                    commit;
    logic                    abort;

    function automatic logic [4:0] decode(input logic [6:0] g);
        case (g)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b0000110: decode = 5'h1E;
            default:    decode = 5'h1F;
        endcase
    endfunction

    // Sample once, then count how long the sampled (hex, dig_sel) pair has held still
    always_ff @(posedge clk) begin
        if (rst) begin
            hex_q <= '0;
            sel_q <= '0;
            cnt   <= '0;
        end else begin
            hex_q <= hex;
            sel_q <= dig_sel;
            if (hex == hex_q && dig_sel == sel_q) begin
                if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= CNT_W'(1);
            end
        end
    end

    assign dec       = decode(hex_q);
    assign stable    = (cnt == CNT_MAX);
    assign cur_mask  = NUM_DIGITS'(1) << idx;
    assign prev_mask = (idx == '0) ? '0 : (NUM_DIGITS'(1) << (idx - IDX_W'(1)));
    // Masks are one-hot, so any multi-hot select is automatically illegal
    assign legal     = (sel_q == '0) || (sel_q == cur_mask) ||
                       ((idx != '0) && (sel_q == prev_mask));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SYNC;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        capture = 1'b0;
        commit  = 1'b0;
        abort   = 1'b0;
        case (state)
            SYNC: begin
                idx_n = '0;
                if (sel_q == NUM_DIGITS'(1)) state_n = SETTLE;
            end
            SETTLE: begin
                if (!legal) begin
                    abort = 1'b1;
                end else if (sel_q == cur_mask && stable) begin
                    capture = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = HOLD;
                    end else begin
                        idx_n   = idx + IDX_W'(1);
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (!legal) begin
                    abort = 1'b1;
                end else if (sel_q == cur_mask) begin
                    state_n = SETTLE;
                end
            end
            HOLD: begin
                commit  = 1'b1;
                state_n = SYNC;
            end
            default: begin
                state_n = SYNC;
            end
        endcase
        if (abort) begin
            state_n = SYNC;
            idx_n   = '0;
        end
    end

    // Shadow frame assembly plus output handshake; a frame arriving while the
    // previous one is still unclaimed is dropped rather than overwriting it
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd <= '0;
            shadow_err <= '0;
            bcd_out    <= '0;
            digit_err  <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            sync_err <= abort;
            if (abort) begin
                shadow_bcd <= '0;
                shadow_err <= '0;
            end else if (capture) begin
                shadow_bcd[{idx, 2'b00} +: 4] <= dec[3:0];
                shadow_err[idx]               <= dec[4];
            end
            if (commit && out_valid && !out_ready) begin
                overrun <= 1'b1;
            end else if (commit) begin
                bcd_out   <= shadow_bcd;
                digit_err <= shadow_err;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_reader.sv
// Bench for seven_segment_reader: directed scan scenarios followed by random
// clean scans, checked against a glyph-table reference model.
module tb_seven_segment_reader;

    localparam int ND = 4;
    localparam int SC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [6:0]    hex;
    logic [ND-1:0] dig_sel;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0] digit_err;
    logic          out_valid;
    logic          out_ready;
    logic          overrun;
    logic          sync_err;

    int checks = 0;
    int errors = 0;

    logic [19:0] acc_q [$];
    int valid_cycles = 0;
    int sync_cnt = 0;

    logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    always #5 clk = ~clk;

    seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst       (rst),
        .hex       (hex),
        .dig_sel   (dig_sel),
        .bcd_out   (bcd_out),
        .digit_err (digit_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .sync_err  (sync_err)
    );

    // Log every accepted frame and every sync_err / out_valid cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) acc_q.push_back({digit_err, bcd_out});
            if (out_valid) valid_cycles++;
            if (sync_err) sync_cnt++;
        end
    end

    function automatic logic [4:0] model_decode(input logic [6:0] g);
        for (int v = 0; v < 10; v++)
            if (glyph_tab[v] == g) return {1'b0, 4'(v)};
        if (g == 7'h06) return 5'h1E;
        return 5'h1F;
    endfunction

    function automatic logic [19:0] model_frame(input logic [27:0] gl);
        logic [15:0] b;
        logic [3:0]  e;
        logic [4:0]  r;
        b = '0;
        e = '0;
        for (int d = 0; d < ND; d++) begin
            r = model_decode(gl[7*d +: 7]);
            b[4*d +: 4] = r[3:0];
            e[d] = r[4];
        end
        return {e, b};
    endfunction

    function automatic logic [19:0] acc_at(input int i);
        if (i < acc_q.size()) return acc_q[i];
        return 20'hxxxxx;
    endfunction

    function automatic logic [27:0] pack4(input logic [6:0] g0, input logic [6:0] g1,
                                          input logic [6:0] g2, input logic [6:0] g3);
        return {g3, g2, g1, g0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [6:0] g, input int n);
        dig_sel = sel;
        hex = g;
        repeat (n) tick();
    endtask

    task automatic apply_stimulus(input logic [27:0] gl, input int dwell, input int gap);
        for (int d = 0; d < ND; d++) begin
            hold(4'(1 << d), gl[7*d +: 7], dwell);
            hold('0, 7'h7F, gap);
        end
    endtask

    task automatic wait_frames(input int target);
        for (int i = 0; i < 80 && acc_q.size() < target; i++) tick();
    endtask

    initial begin
        int base;
        int vbase;
        int sbase;
        logic [27:0] gl;
        logic [19:0] exp_q [$];
        int r;

        rst = 1'b1;
        hex = 7'h7F;
        dig_sel = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_output("reset_bcd", 32'(bcd_out), 32'h0);
        check_output("reset_err", 32'(digit_err), 32'h0);
        check_output("reset_valid", 32'(out_valid), 32'h0);
        check_output("reset_overrun", 32'(overrun), 32'h0);
        check_output("reset_sync", 32'(sync_err), 32'h0);
        rst = 1'b0;
        tick();

        $display("[TB] basic 0-1-2-3 scan");
        base = acc_q.size();
        vbase = valid_cycles;
        apply_stimulus(pack4(7'h40, 7'h79, 7'h24, 7'h30), 8, 2);
        wait_frames(base + 1);
        repeat (3) tick();
        check_output("t1_count", 32'(acc_q.size()), 32'(base + 1));
        check_output("t1_frame", 32'(acc_at(base)), 32'h0_3210);
        check_output("t1_pulse", 32'(valid_cycles - vbase), 32'd1);

        $display("[TB] E and unrecognised glyphs");
        base = acc_q.size();
        apply_stimulus(pack4(7'h00, 7'h2A, 7'h06, 7'h12), 8, 2);
        wait_frames(base + 1);
        check_output("t2_frame", 32'(acc_at(base)), 32'h6_5EF8);

        $display("[TB] overrun with consumer stalled");
        out_ready = 1'b0;
        apply_stimulus(pack4(7'h10, 7'h00, 7'h78, 7'h02), 8, 2);
        for (int i = 0; i < 60 && !out_valid; i++) tick();
        check_output("t3_valid", 32'(out_valid), 32'd1);
        check_output("t3_first", 32'(bcd_out), 32'h6789);
        check_output("t3_no_overrun", 32'(overrun), 32'd0);
        apply_stimulus(pack4(7'h79, 7'h24, 7'h30, 7'h19), 8, 2);
        repeat (2) tick();
        check_output("t3_held", 32'(bcd_out), 32'h6789);
        check_output("t3_overrun", 32'(overrun), 32'd1);
        check_output("t3_still_valid", 32'(out_valid), 32'd1);
        base = acc_q.size();
        out_ready = 1'b1;
        tick();
        check_output("t3_drop", 32'(out_valid), 32'd0);
        check_output("t3_accept", 32'(acc_at(base)), 32'h0_6789);

        $display("[TB] scan order violation");
        base = acc_q.size();
        sbase = sync_cnt;
        hold(4'b0001, 7'h40, 8);
        hold('0, 7'h7F, 2);
        hold(4'b0010, 7'h79, 8);
        hold('0, 7'h7F, 2);
        hold(4'b1000, 7'h30, 8);
        hold('0, 7'h7F, 3);
        check_output("t4_sync_pulse", 32'(sync_cnt - sbase), 32'd1);
        check_output("t4_no_frame", 32'(acc_q.size()), 32'(base));
        apply_stimulus(pack4(7'h12, 7'h02, 7'h78, 7'h00), 8, 2);
        wait_frames(base + 1);
        check_output("t4_recover", 32'(acc_at(base)), 32'h0_8765);

        $display("[TB] short dwell on digit 1");
        base = acc_q.size();
        sbase = sync_cnt;
        hold(4'b0001, 7'h19, 8);
        hold('0, 7'h7F, 2);
        hold(4'b0010, 7'h12, SC - 1);
        hold('0, 7'h7F, 2);
        hold(4'b0010, 7'h12, 8);
        hold('0, 7'h7F, 2);
        hold(4'b0100, 7'h02, 8);
        hold('0, 7'h7F, 2);
        hold(4'b1000, 7'h78, 8);
        hold('0, 7'h7F, 2);
        wait_frames(base + 1);
        repeat (2) tick();
        check_output("t5_count", 32'(acc_q.size()), 32'(base + 1));
        check_output("t5_frame", 32'(acc_at(base)), 32'h0_7654);
        check_output("t5_no_sync", 32'(sync_cnt - sbase), 32'd0);

        $display("[TB] reset mid-frame");
        out_ready = 1'b0;
        apply_stimulus(pack4(7'h79, 7'h79, 7'h79, 7'h79), 8, 2);
        apply_stimulus(pack4(7'h24, 7'h24, 7'h24, 7'h24), 8, 2);
        out_ready = 1'b1;
        hold(4'b0001, 7'h40, 8);
        hold(4'b0010, 7'h79, 8);
        hold(4'b0100, 7'h24, 3);
        rst = 1'b1;
        tick();
        check_output("t6_bcd", 32'(bcd_out), 32'h0);
        check_output("t6_err", 32'(digit_err), 32'h0);
        check_output("t6_valid", 32'(out_valid), 32'h0);
        check_output("t6_overrun", 32'(overrun), 32'h0);
        check_output("t6_sync", 32'(sync_err), 32'h0);
        rst = 1'b0;
        hold(4'b0100, 7'h24, 3);
        hold('0, 7'h7F, 2);
        base = acc_q.size();
        apply_stimulus(pack4(7'h30, 7'h24, 7'h79, 7'h40), 8, 2);
        wait_frames(base + 1);
        check_output("t6_fresh", 32'(acc_at(base)), 32'h0_0123);

        $display("[TB] random clean scans");
        base = acc_q.size();
        for (int f = 0; f < 6; f++) begin
            for (int d = 0; d < ND; d++) begin
                r = $urandom_range(0, 11);
                if (r < 10) gl[7*d +: 7] = glyph_tab[r];
                else if (r == 10) gl[7*d +: 7] = 7'h06;
                else gl[7*d +: 7] = 7'($urandom);
            end
            exp_q.push_back(model_frame(gl));
            apply_stimulus(gl, $urandom_range(SC, SC + 5), $urandom_range(0, 3));
        end
        hold('0, 7'h7F, 3);
        wait_frames(base + 6);
        check_output("rand_count", 32'(acc_q.size()), 32'(base + 6));
        for (int f = 0; f < 6; f++)
            check_output($sformatf("rand_frame%0d", f), 32'(acc_at(base + f)), 32'(exp_q[f]));
        check_output("rand_overrun", 32'(overrun), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
